// File: rtl/data_mem_responder_if.sv
// Data-memory request/ack bus between the load/store unit (master) and the
// memory responder (slave).
interface data_mem_responder_if;
    logic [31:0] address;
    logic        read_enable;
    logic [31:0] read_data;
    logic        read_ack;
    logic        write_enable;
    logic [3:0]  write_byte_enable;
    logic [31:0] write_data;
    logic        write_ack;
    logic        access_error;
    logic        protocol_error;

    modport master (
        output address, read_enable, write_enable, write_byte_enable, write_data,
        input  read_data, read_ack, write_ack, access_error, protocol_error
    );

    modport slave (
        input  address, read_enable, write_enable, write_byte_enable, write_data,
        output read_data, read_ack, write_ack, access_error, protocol_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed RAM responder: accepts single-cycle read/write pulses and returns a
// single-cycle ack after a fixed number of wait states.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter string       INIT_FILE     = ""
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WindowBytes = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            is_write_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic            in_range_q;
    logic [31:0]     read_data_q;
    logic            read_ack_q;
    logic            write_ack_q;
    logic            access_error_q;
    logic            protocol_error_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic [31:0]     offset;
    logic            req_in_range;
    logic [AW-1:0]   req_idx;
    logic [3:0]      req_lat;
    logic            accept;
    logic            proto_err;
    logic            enter_ack;
    logic            acc_write;
    logic [AW-1:0]   acc_idx;
    logic [3:0]      acc_be;
    logic [31:0]     acc_wdata;
    logic            acc_in_range;

    always_comb begin
        // Subtraction wraps below BASE_ADDR, so one unsigned compare covers both bounds.
        offset       = bus.address - BASE_ADDR;
        req_in_range = ({1'b0, offset} < WindowBytes);
        req_idx      = offset[AW+1:2];
        req_lat      = bus.write_enable ? 4'(WRITE_LATENCY) : 4'(READ_LATENCY);
        accept       = (state_q == StIdle) && (bus.read_enable ^ bus.write_enable);
        proto_err    = (bus.read_enable && bus.write_enable) ||
                       ((bus.read_enable || bus.write_enable) && (state_q != StIdle));
        enter_ack    = 1'b0;
        acc_write    = is_write_q;
        acc_idx      = idx_q;
        acc_be       = be_q;
        acc_wdata    = wdata_q;
        acc_in_range = in_range_q;
        if (accept) begin
            enter_ack    = (req_lat == 4'd1);
            acc_write    = bus.write_enable;
            acc_idx      = req_idx;
            acc_be       = bus.write_byte_enable;
            acc_wdata    = bus.write_data;
            acc_in_range = req_in_range;
        end else if (state_q == StWait) begin
            enter_ack = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            cnt_q            <= 4'd0;
            is_write_q       <= 1'b0;
            idx_q            <= '0;
            be_q             <= 4'd0;
            wdata_q          <= 32'd0;
            in_range_q       <= 1'b0;
            read_data_q      <= 32'd0;
            read_ack_q       <= 1'b0;
            write_ack_q      <= 1'b0;
            access_error_q   <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            read_ack_q     <= 1'b0;
            write_ack_q    <= 1'b0;
            access_error_q <= 1'b0;
            if (proto_err) protocol_error_q <= 1'b1;
            if (accept) begin
                is_write_q <= bus.write_enable;
                idx_q      <= req_idx;
                be_q       <= bus.write_byte_enable;
                wdata_q    <= bus.write_data;
                in_range_q <= req_in_range;
            end
            if (enter_ack) begin
                state_q        <= StAck;
                cnt_q          <= 4'd0;
                read_ack_q     <= !acc_write;
                write_ack_q    <= acc_write;
                access_error_q <= !acc_in_range;
                if (!acc_write) read_data_q <= acc_in_range ? mem_q[acc_idx] : 32'd0;
            end else begin
                case (state_q)
                    StIdle: if (accept) begin
                        state_q <= StWait;
                        cnt_q   <= req_lat - 4'd1;
                    end
                    StWait:  cnt_q   <= cnt_q - 4'd1;
                    StAck:   state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // RAM is never reset; a reset on the commit edge must still suppress the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && acc_write && acc_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign bus.read_data      = read_data_q;
    assign bus.read_ack       = read_ack_q;
    assign bus.write_ack      = write_ack_q;
    assign bus.access_error   = access_error_q;
    assign bus.protocol_error = protocol_error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut0 uses default latencies (read 2, write 1); dut1 uses latency 3
// with a small window at 0x1000 for reset-abort and below-base cases.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();

    data_mem_responder dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (b0)
    );

    data_mem_responder #(
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (32'h0000_1000),
        .READ_LATENCY  (3),
        .WRITE_LATENCY (3)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Request pulse in the current cycle; inputs are scrambled afterwards.
    task automatic drive0(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        b0.read_enable       = rd;
        b0.write_enable      = wr;
        b0.address           = a;
        b0.write_byte_enable = be;
        b0.write_data        = d;
        @(negedge clk);
        b0.read_enable       = 1'b0;
        b0.write_enable      = 1'b0;
        b0.address           = 32'hFFFF_FFF0;
        b0.write_byte_enable = 4'hF;
        b0.write_data        = 32'h5555_5555;
    endtask

    task automatic read0(input logic [31:0] a, input logic [31:0] exp, input logic err,
                         input string tag);
        drive0(1'b1, 1'b0, a, 4'h0, 32'h0);
        chk({tag, "_rack_c1"}, b0.read_ack, 1'b0);
        @(negedge clk);
        chk({tag, "_rack_c2"}, b0.read_ack, 1'b1);
        chk({tag, "_wack_c2"}, b0.write_ack, 1'b0);
        chk({tag, "_data"}, b0.read_data, exp);
        chk({tag, "_aerr"}, b0.access_error, err);
        @(negedge clk);
        chk({tag, "_rack_c3"}, b0.read_ack, 1'b0);
        chk({tag, "_held"}, b0.read_data, exp);
        chk({tag, "_aerr_c3"}, b0.access_error, 1'b0);
    endtask

    task automatic write0(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                          input logic err, input string tag);
        drive0(1'b0, 1'b1, a, be, d);
        chk({tag, "_wack_c1"}, b0.write_ack, 1'b1);
        chk({tag, "_rack_c1"}, b0.read_ack, 1'b0);
        chk({tag, "_aerr"}, b0.access_error, err);
        @(negedge clk);
        chk({tag, "_wack_c2"}, b0.write_ack, 1'b0);
    endtask

    // Full-mask op on dut1; abort_cyc != 0 raises rst1 during that cycle.
    task automatic op1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int abort_cyc, input logic [31:0] exp_rd, input logic exp_err,
                       input string tag);
        logic exp_ack;
        b1.address           = a;
        b1.write_enable      = wr;
        b1.read_enable       = !wr;
        b1.write_byte_enable = 4'hF;
        b1.write_data        = d;
        @(negedge clk);
        b1.read_enable  = 1'b0;
        b1.write_enable = 1'b0;
        b1.address      = 32'h0;
        b1.write_data   = 32'h0;
        for (int c = 1; c <= 5; c++) begin
            rst1    = (c == abort_cyc);
            exp_ack = (abort_cyc == 0) && (c == 3);
            chk($sformatf("%s_ack_c%0d", tag, c), wr ? b1.write_ack : b1.read_ack, exp_ack);
            if (exp_ack) begin
                chk({tag, "_aerr"}, b1.access_error, exp_err);
                if (!wr) chk({tag, "_data"}, b1.read_data, exp_rd);
            end
            if (abort_cyc != 0 && c == abort_cyc + 1 && !wr)
                chk({tag, "_rdata_rst"}, b1.read_data, 32'h0);
            @(negedge clk);
        end
        rst1 = 1'b0;
    endtask

    initial begin
        b0.read_enable = 1'b0; b0.write_enable = 1'b0; b0.address = 32'h0;
        b0.write_byte_enable = 4'h0; b0.write_data = 32'h0;
        b1.read_enable = 1'b0; b1.write_enable = 1'b0; b1.address = 32'h0;
        b1.write_byte_enable = 4'h0; b1.write_data = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdata", b0.read_data, 32'h0);
        chk("rst_rack", b0.read_ack, 1'b0);
        chk("rst_wack", b0.write_ack, 1'b0);
        chk("rst_aerr", b0.access_error, 1'b0);
        chk("rst_perr", b0.protocol_error, 1'b0);
        chk("rst1_rdata", b1.read_data, 32'h0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Basic read of a preloaded word.
        write0(32'h10, 4'hF, 32'h1122_3344, 1'b0, "pre4");
        read0(32'h10, 32'h1122_3344, 1'b0, "rd4");

        // Byte-masked writes.
        write0(32'h14, 4'hF, 32'h0, 1'b0, "clr5");
        write0(32'h14, 4'b0100, 32'hAABB_CCDD, 1'b0, "wm5");
        read0(32'h14, 32'h00BB_0000, 1'b0, "rd5a");
        write0(32'h14, 4'b0000, 32'hFFFF_FFFF, 1'b0, "wz5");
        read0(32'h14, 32'h00BB_0000, 1'b0, "rd5b");

        // Back-to-back write then read, and low address bits ignored.
        write0(32'h20, 4'hF, 32'hCAFE_F00D, 1'b0, "w8");
        read0(32'h20, 32'hCAFE_F00D, 1'b0, "rd8");
        chk("b2b_perr", b0.protocol_error, 1'b0);
        read0(32'h23, 32'hCAFE_F00D, 1'b0, "rd8u");

        // Out-of-range accesses; writes must not alias into the window.
        read0(32'h1000, 32'h0, 1'b1, "rd_oor");
        write0(32'h1014, 4'hF, 32'h1234_5678, 1'b1, "w_oor5");
        write0(32'h1010, 4'hF, 32'h8765_4321, 1'b1, "w_oor4");
        read0(32'h14, 32'h00BB_0000, 1'b0, "rd5c");
        read0(32'h10, 32'h1122_3344, 1'b0, "rd4b");
        chk("perr_clean", b0.protocol_error, 1'b0);

        // Both enables together: dropped, sticky error.
        drive0(1'b1, 1'b1, 32'h10, 4'hF, 32'h0);
        chk("both_perr", b0.protocol_error, 1'b1);
        chk("both_rack_c1", b0.read_ack, 1'b0);
        chk("both_wack_c1", b0.write_ack, 1'b0);
        @(negedge clk);
        chk("both_rack_c2", b0.read_ack, 1'b0);
        chk("both_wack_c2", b0.write_ack, 1'b0);

        // Legal read, then an illegal read pulse during WAIT.
        drive0(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        b0.read_enable = 1'b1;
        b0.address     = 32'h14;
        @(negedge clk);
        b0.read_enable = 1'b0;
        chk("wait_rack_c2", b0.read_ack, 1'b1);
        chk("wait_data", b0.read_data, 32'h1122_3344);
        @(negedge clk);
        chk("wait_rack_c3", b0.read_ack, 1'b0);
        @(negedge clk);
        chk("wait_rack_c4", b0.read_ack, 1'b0);
        chk("wait_data_c4", b0.read_data, 32'h1122_3344);
        chk("perr_sticky", b0.protocol_error, 1'b1);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        chk("perr_rst", b0.protocol_error, 1'b0);
        chk("rdata_rst", b0.read_data, 32'h0);

        // Latency-3 responder: normal ops, aborts and below-base access.
        op1(1'b1, 32'h1008, 32'h5A5A_5A5A, 0, 32'h0, 1'b0, "w1");
        op1(1'b0, 32'h1008, 32'h0, 0, 32'h5A5A_5A5A, 1'b0, "r1");
        op1(1'b0, 32'h1008, 32'h0, 1, 32'h0, 1'b0, "r1_abort");
        op1(1'b1, 32'h1008, 32'h0, 1, 32'h0, 1'b0, "w1_abort1");
        op1(1'b1, 32'h1008, 32'h0, 2, 32'h0, 1'b0, "w1_abort2");
        op1(1'b0, 32'h1008, 32'h0, 0, 32'h5A5A_5A5A, 1'b0, "r1_after");
        op1(1'b0, 32'h0FFC, 32'h0, 0, 32'h0, 1'b1, "r1_below");
        chk("dut1_perr", b1.protocol_error, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
